// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle for dm_cache_ctrl.
//   Processor side : Addr, DataIn, Rd, Wr (requests) / DataOut, Done, Stall, CacheHit, err (responses)
//   Memory side    : mem_req, mem_we, mem_addr, mem_wdata (requests) / mem_stall, mem_rvalid, mem_rdata
// slave  = the cache controller; master = the processor plus backing memory around it.
interface dm_cache_ctrl_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    modport slave (
        input  Addr, DataIn, Rd, Wr, mem_stall, mem_rvalid, mem_rdata,
        output DataOut, Done, Stall, CacheHit, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output Addr, DataIn, Rd, Wr, mem_stall, mem_rvalid, mem_rdata,
        input  DataOut, Done, Stall, CacheHit, err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 4-word lines of 16-bit words, byte addressed (Addr[0] must be 0).
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous reset, active-low
//   bus  - dm_cache_ctrl_if.slave: processor request/response and backing-memory request/read-return
//
// state  | meaning
// DRAIN  | after reset, wait MEM_LAT+1 cycles so reads still in flight fall on the floor
// IDLE   | accept a request; illegal requests answered here with err
// LOOKUP | tag compare; hit completes, miss picks WB or FILL
// WB     | write the 4 words of a dirty victim back to memory
// FILL   | read the 4 words of the requested line, then re-run LOOKUP
module dm_cache_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int MEM_LAT    = 2
) (
    input  logic clk,
    input  logic rst,
    dm_cache_ctrl_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 13 - INDEX_BITS;
    localparam int DCW      = $clog2(MEM_LAT + 2);

    typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_LOOKUP, S_WB, S_FILL} state_t;
    state_t state_q, state_d;

    logic [TAG_BITS-1:0] tag_arr [LINES];
    logic [15:0]         data_arr [LINES*4];
    logic [LINES-1:0]    valid_q, dirty_q;

    logic [15:1]     req_addr;
    logic [15:0]     req_data;
    logic            req_we;
    logic            miss_flag;
    logic [2:0]      issue_cnt;
    logic [1:0]      rcv_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic            done_q, hit_q, err_q;
    logic [15:0]     dout_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_off;
    logic hit, victim_dirty, req_seen, illegal, issue_ok;

    assign req_idx      = req_addr[2+INDEX_BITS:3];
    assign req_tag      = req_addr[15:3+INDEX_BITS];
    assign req_off      = req_addr[2:1];
    assign hit          = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
    // A request still held high during the Done cycle belongs to the finished operation.
    assign req_seen     = ~done_q & (bus.Rd | bus.Wr);
    assign illegal      = (bus.Rd & bus.Wr) | bus.Addr[0];
    assign issue_ok     = bus.mem_req & ~bus.mem_stall;

    assign bus.Done     = done_q;
    assign bus.CacheHit = hit_q;
    assign bus.err      = err_q;
    assign bus.DataOut  = dout_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_DRAIN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DRAIN:  if (drain_cnt == '0) state_d = S_IDLE;
            S_IDLE:   if (req_seen && !illegal) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_IDLE : (victim_dirty ? S_WB : S_FILL);
            S_WB:     if (issue_ok && issue_cnt[1:0] == 2'd3) state_d = S_FILL;
            S_FILL:   if (bus.mem_rvalid && rcv_cnt == 2'd3) state_d = S_LOOKUP;
            default:  state_d = S_DRAIN;
        endcase
    end

    // Memory request is a pure function of state and issue counter, so it stays
    // frozen while mem_stall holds the counter.
    always_comb begin
        bus.Stall     = (state_q != S_IDLE);
        bus.mem_req   = (state_q == S_WB) || (state_q == S_FILL && !issue_cnt[2]);
        bus.mem_we    = (state_q == S_WB);
        bus.mem_addr  = (state_q == S_WB) ? {tag_arr[req_idx], req_idx, issue_cnt[1:0], 1'b0}
                                          : {req_tag, req_idx, issue_cnt[1:0], 1'b0};
        bus.mem_wdata = data_arr[{req_idx, issue_cnt[1:0]}];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drain_cnt <= DCW'(MEM_LAT);
            valid_q   <= '0;
            dirty_q   <= '0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            miss_flag <= 1'b0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_we    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - DCW'(1);
                S_IDLE: begin
                    miss_flag <= 1'b0;
                    if (req_seen) begin
                        req_addr <= bus.Addr[15:1];
                        req_data <= bus.DataIn;
                        req_we   <= bus.Wr;
                        if (illegal) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (req_we) dirty_q[req_idx] <= 1'b1;
                        else        dout_q <= data_arr[{req_idx, req_off}];
                        done_q <= 1'b1;
                        hit_q  <= ~miss_flag;
                    end else begin
                        // Line is invalid until the refill completes, so an abort
                        // part way through never leaves a half-filled valid line.
                        miss_flag        <= 1'b1;
                        issue_cnt        <= '0;
                        rcv_cnt          <= '0;
                        valid_q[req_idx] <= 1'b0;
                    end
                end
                S_WB: begin
                    if (issue_ok) begin
                        if (issue_cnt[1:0] == 2'd3) begin
                            issue_cnt        <= '0;
                            dirty_q[req_idx] <= 1'b0;
                        end else begin
                            issue_cnt <= issue_cnt + 3'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (issue_ok) issue_cnt <= issue_cnt + 3'd1;
                    if (bus.mem_rvalid) begin
                        rcv_cnt <= rcv_cnt + 2'd1;
                        if (rcv_cnt == 2'd3) begin
                            valid_q[req_idx] <= 1'b1;
                            dirty_q[req_idx] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == S_LOOKUP && hit && req_we)
                data_arr[{req_idx, req_off}] <= req_data;
            if (state_q == S_FILL && bus.mem_rvalid) begin
                data_arr[{req_idx, rcv_cnt}] <= bus.mem_rdata;
                if (rcv_cnt == 2'd3) tag_arr[req_idx] <= req_tag;
            end
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed requests against a pipelined backing-memory model.
// Expected responses and expected memory transactions go into queues when a request is
// issued; monitors pop and compare whenever Done pulses or memory accepts a request.
module tb_dm_cache_ctrl;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_cache_ctrl_if bus();

    dm_cache_ctrl #(.INDEX_BITS(5), .MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        chk_data;
        logic        hit;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } memop_t;

    resp_t  resp_q[$];
    memop_t mem_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] mem [0:32767];
    logic        p0_v = 1'b0, p1_v = 1'b0;
    logic [15:0] p0_d = '0, p1_d = '0;
    logic        acc_rd = 1'b0, acc_wr = 1'b0;
    logic [15:0] acc_addr = '0, acc_wdata = '0;
    logic        prev_held = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = '0, prev_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Backing memory: writes land at acceptance, reads return MEM_LAT cycles after acceptance.
    always @(posedge clk) begin
        p1_v <= p0_v;
        p1_d <= p0_d;
        p0_v <= acc_rd;
        p0_d <= mem[acc_addr[15:1]];
        if (acc_wr) mem[acc_addr[15:1]] <= acc_wdata;
    end
    assign bus.mem_rvalid = p1_v;
    assign bus.mem_rdata  = p1_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: sampled just after the falling edge, well away from the active edge.
    always @(negedge clk) begin
        resp_t  r;
        memop_t m;
        #1;
        if (bus.Done) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: Done=1 at cycle %0d with nothing pending", cyc);
            end else begin
                r = resp_q.pop_front();
                if ((r.chk_data && bus.DataOut != r.data) || bus.CacheHit != r.hit ||
                    bus.err != r.err || cyc != r.cyc) begin
                    errors++;
                    $display("FAIL resp addr=0x%04h: got data=0x%04h hit=%0b err=%0b cyc=%0d expected data=0x%04h hit=%0b err=%0b cyc=%0d",
                             r.addr, bus.DataOut, bus.CacheHit, bus.err, cyc, r.data, r.hit, r.err, r.cyc);
                end
            end
        end

        acc_rd    = bus.mem_req & ~bus.mem_we & ~bus.mem_stall;
        acc_wr    = bus.mem_req &  bus.mem_we & ~bus.mem_stall;
        acc_addr  = bus.mem_addr;
        acc_wdata = bus.mem_wdata;

        if (prev_held) begin
            checks++;
            if (!bus.mem_req || bus.mem_we != prev_we || bus.mem_addr != prev_addr ||
                (prev_we && bus.mem_wdata != prev_wdata)) begin
                errors++;
                $display("FAIL mem_hold: got req=%0b we=%0b addr=0x%04h expected req=1 we=%0b addr=0x%04h",
                         bus.mem_req, bus.mem_we, bus.mem_addr, prev_we, prev_addr);
            end
        end
        prev_held  = bus.mem_req & bus.mem_stall;
        prev_we    = bus.mem_we;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;

        if (acc_rd || acc_wr) begin
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: we=%0b addr=0x%04h at cycle %0d", acc_wr, acc_addr, cyc);
            end else begin
                m = mem_q.pop_front();
                if (acc_wr != m.we || acc_addr != m.addr || (m.we && acc_wdata != m.data)) begin
                    errors++;
                    $display("FAIL mem_op: got we=%0b addr=0x%04h wdata=0x%04h expected we=%0b addr=0x%04h wdata=0x%04h",
                             acc_wr, acc_addr, acc_wdata, m.we, m.addr, m.data);
                end
            end
        end
    end

    task automatic exp_mem(input logic we, input logic [15:0] addr, input logic [15:0] data);
        memop_t m;
        m.we = we; m.addr = addr; m.data = data;
        mem_q.push_back(m);
    endtask

    task automatic exp_fill(input logic [15:0] base);
        for (int i = 0; i < 4; i++) exp_mem(1'b0, base + 16'(2 * i), 16'h0000);
    endtask

    task automatic count_drain(input string name);
        int nstall, ndone;
        nstall = 0;
        ndone  = 0;
        while (bus.Stall && nstall < 50) begin
            nstall++;
            if (bus.Done) ndone++;
            @(negedge clk);
        end
        chk({name, "_drain_cycles"}, nstall, MEM_LAT + 1);
        chk({name, "_no_done"}, ndone, 0);
    endtask

    // lat: cycles from request (cycle 0) to Done. rst_at >= 0 aborts with reset at that cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din,
                          input logic [15:0] exp_data, input logic chk_data, input logic exp_hit,
                          input logic exp_err, input int lat, input int stall_at, input int stall_len,
                          input int rst_at);
        int    start, k;
        logic  seen, stall_bad;
        resp_t r;
        @(negedge clk);
        bus.Rd = rd; bus.Wr = wr; bus.Addr = addr; bus.DataIn = din;
        start = cyc;
        if (rst_at < 0) begin
            r.addr = addr; r.data = exp_data; r.chk_data = chk_data;
            r.hit = exp_hit; r.err = exp_err; r.cyc = start + lat;
            resp_q.push_back(r);
        end
        seen = 1'b0;
        stall_bad = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            k = cyc - start;
            bus.mem_stall = (k >= stall_at) && (k < stall_at + stall_len);
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b0;
                bus.Rd = 1'b0;
                bus.Wr = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                mem_q.delete();
                count_drain("abort");
                seen = 1'b1;
                break;
            end
            if (bus.Done) begin
                seen = 1'b1;
                break;
            end
            if (!bus.Stall) stall_bad = 1'b1;
        end
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
        bus.mem_stall = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=0x%04h: no Done within 200 cycles", addr);
        end else if (rst_at < 0 && lat > 1) begin
            chk("stall_until_done", int'(stall_bad), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i * 2);
        rst = 1'b0;
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0; bus.mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done",     int'(bus.Done),     0);
        chk("rst_hit",      int'(bus.CacheHit), 0);
        chk("rst_err",      int'(bus.err),      0);
        chk("rst_dataout",  int'(bus.DataOut),  0);
        chk("rst_stall",    int'(bus.Stall),    1);
        chk("rst_mem_req",  int'(bus.mem_req),  0);
        chk("rst_mem_we",   int'(bus.mem_we),   0);
        rst = 1'b1;
        count_drain("init");

        // clean miss
        exp_fill(16'h0010);
        do_req(1, 0, 16'h0010, 16'h0000, 16'h1010, 1, 0, 0, 9, -1, 0, -1);
        // write hit, then read it back
        do_req(0, 1, 16'h0012, 16'hBEEF, 16'h0000, 0, 1, 0, 2, -1, 0, -1);
        do_req(1, 0, 16'h0012, 16'h0000, 16'hBEEF, 1, 1, 0, 2, -1, 0, -1);
        do_req(1, 0, 16'h0014, 16'h0000, 16'h1014, 1, 1, 0, 2, -1, 0, -1);
        // dirty victim: writeback then fill
        exp_mem(1, 16'h0010, 16'h1010);
        exp_mem(1, 16'h0012, 16'hBEEF);
        exp_mem(1, 16'h0014, 16'h1014);
        exp_mem(1, 16'h0016, 16'h1016);
        exp_fill(16'h0110);
        do_req(1, 0, 16'h0112, 16'h0000, 16'h1112, 1, 0, 0, 13, -1, 0, -1);
        // memory stall during fill issue
        exp_fill(16'h0220);
        do_req(1, 0, 16'h0224, 16'h0000, 16'h1224, 1, 0, 0, 12, 3, 3, -1);
        // illegal requests
        do_req(1, 1, 16'h0010, 16'h1234, 16'h0000, 0, 0, 1, 1, -1, 0, -1);
        do_req(1, 0, 16'h0011, 16'h0000, 16'h0000, 0, 0, 1, 1, -1, 0, -1);
        do_req(0, 1, 16'h0013, 16'hDEAD, 16'h0000, 0, 0, 1, 1, -1, 0, -1);
        // line 2 untouched by the illegal write
        do_req(1, 0, 16'h0112, 16'h0000, 16'h1112, 1, 1, 0, 2, -1, 0, -1);
        // written-back data comes back from memory
        exp_fill(16'h0010);
        do_req(1, 0, 16'h0012, 16'h0000, 16'hBEEF, 1, 0, 0, 9, -1, 0, -1);
        // reset mid-fill with reads in flight
        exp_fill(16'h0330);
        do_req(1, 0, 16'h0330, 16'h0000, 16'h0000, 0, 0, 0, 0, -1, 0, 4);
        exp_fill(16'h0330);
        do_req(1, 0, 16'h0336, 16'h0000, 16'h1336, 1, 0, 0, 9, -1, 0, -1);
        // reset dropped every line
        exp_fill(16'h0010);
        do_req(1, 0, 16'h0012, 16'h0000, 16'hBEEF, 1, 0, 0, 9, -1, 0, -1);

        repeat (4) @(negedge clk);
        chk("resp_q_empty", resp_q.size(), 0);
        chk("mem_q_empty",  mem_q.size(),  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
